apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB master stage that consumes the command-side signals of the APB interface
//  (transfer, READ_WRITE, write/read address, write data) and drives the APB bus
//  to the two slaves. It returns read data and PSLVERR to the command side.
//  The address MSB selects the slave; the remaining bits form PADDR.
//  A three-state FSM (IDLE/SETUP/ACCESS) handles wait states, back-to-back
//  transfers and a PREADY timeout.
// PARAMETERS
//  ADDR_WIDTH      9   command address width; MSB = slave select, PADDR = low ADDR_WIDTH-1 bits
//  DATA_WIDTH      8   APB data width
//  TIMEOUT_CYCLES  16  max consecutive ACCESS cycles with PREADY low before abort; 0 = no timeout
// PORTS
//  PCLK               in   1            clock; all logic on rising edge
//  PRESET             in   1            synchronous reset, active-high
//  transfer           in   1            request a transfer; sampled only in IDLE (and at completion)
//  READ_WRITE         in   1            1 = read, 0 = write
//  apb_write_paddr    in   ADDR_WIDTH   write address
//  apb_read_paddr     in   ADDR_WIDTH   read address
//  apb_write_data     in   DATA_WIDTH   write data
//  apb_read_data_out  out  DATA_WIDTH   last completed read data (registered)
//  PSLVERR            out  1            error status of the last completed transfer (registered)
//  xfer_done          out  1            1-cycle pulse at the completion or abort of a transfer
//  busy               out  1            high whenever FSM != IDLE
//  PSEL1, PSEL2       out  1            slave selects; one-hot or both zero
//  PENABLE            out  1            APB enable
//  PWRITE             out  1            APB direction, 1 = write
//  PADDR              out  ADDR_WIDTH-1 APB address
//  PWDATA             out  DATA_WIDTH   APB write data
//  PRDATA1, PRDATA2   in   DATA_WIDTH   slave read data
//  PREADY1, PREADY2   in   1            slave ready
//  PSLVERR1, PSLVERR2 in   1            slave error
// BEHAVIOUR
//  - Reset (PRESET=1 at an edge): FSM -> IDLE, timeout counter = 0.
//    All outputs go to 0 at that edge, including the read data and error registers.
//    A reset mid-transfer aborts it with no xfer_done pulse.
//  - Command capture happens on the IDLE->SETUP edge:
//    * Address = READ_WRITE ? apb_read_paddr : apb_write_paddr.
//    * Write data and direction are captured too.
//    * Command inputs are ignored while busy.
//  - Slave select: captured addr[ADDR_WIDTH-1] = 0 -> PSEL1, 1 -> PSEL2.
//    PREADY, PRDATA and PSLVERR are taken from the selected slave only.
//  - FSM transitions:
//    * IDLE: transfer=1 -> SETUP.
//    * SETUP (PSEL=1, PENABLE=0): always -> ACCESS after one cycle.
//    * ACCESS (PSEL=1, PENABLE=1):
//      PREADY=1 -> complete; then transfer=1 -> SETUP with a fresh capture, else -> IDLE.
//      PREADY=0 -> stay in ACCESS.
//  - PADDR, PWRITE and PWDATA are stable from SETUP through the final ACCESS cycle.
//  - Latency: transfer high at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2.
//    With zero wait states, xfer_done, read data and PSLVERR are valid in cycle N+3.
//  - Completion edge:
//    * On a read, apb_read_data_out <= PRDATA; on a write it is unchanged.
//    * PSLVERR <= selected PSLVERRx; xfer_done = 1 for one cycle.
//    * Both registers hold until the next completion.
//  - Timeout:
//    * The counter increments on each ACCESS cycle with PREADY=0.
//    * If PREADY is still 0 on the TIMEOUT_CYCLES-th such cycle, the transfer aborts at that edge.
//    * Abort: PSEL/PENABLE drop, PSLVERR <= 1, xfer_done pulses, read data unchanged.
//    * After an abort the FSM goes to IDLE regardless of transfer.
//    * The counter clears on entry to SETUP.
//  - Back-to-back: there is no IDLE cycle between transfers.
//    PSEL stays high if the same slave is selected; it switches one-hot if the slave changes.
// TESTING
//  1 Zero-wait write: transfer=1, RW=0, wpaddr=0x012, wdata=0xA5, PREADY1=1
//    -> PSEL1 for 2 cycles, PADDR=0x12, PWDATA=0xA5, xfer_done at cycle 3, PSLVERR=0.
//  2 Read with 3 wait states from slave 2: rpaddr=0x1F0, PRDATA2=0x3C, PREADY2 low 3 cycles
//    -> 4 ACCESS cycles, apb_read_data_out=0x3C, PSEL1 never high.
//  3 Back-to-back: transfer held high; write 0x005 then read 0x105
//    -> ACCESS->SETUP with no IDLE, PSEL1->PSEL2, two xfer_done pulses.
//  4 Timeout: TIMEOUT_CYCLES=16, PREADY1 stuck low
//    -> abort after 16 ACCESS cycles, PSLVERR=1, read data unchanged.
//  5 Slave error: PSLVERR2=1 with PREADY2=1 on a read
//    -> PSLVERR=1; the next clean transfer clears it to 0.
//  6 PRESET asserted during ACCESS -> all outputs 0 at the next edge, FSM in IDLE, no xfer_done.

Source files
------------

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// APB master stage. It accepts a command (transfer request, direction,
// read/write address, write data) and runs it as a SETUP + ACCESS sequence on
// an APB bus shared by two slaves. It returns the read data and the
// slave-error status of the last completed transfer to the command side.
//
// The command address MSB selects the slave: 0 -> slave 1, 1 -> slave 2.
// The remaining ADDR_WIDTH-1 bits drive PADDR.
//
// A PREADY timeout aborts an ACCESS phase that has been stalled for
// TIMEOUT_CYCLES consecutive cycles. An abort reports PSLVERR = 1 and leaves
// the read data unchanged. A TIMEOUT_CYCLES value of 0 disables the timeout.
//
// Ports
//   PCLK, PRESET        clock (rising edge), synchronous active-high reset
//   transfer            command request; sampled in IDLE and at completion
//   READ_WRITE          1 = read, 0 = write
//   apb_write_paddr     write address    (ADDR_WIDTH)
//   apb_read_paddr      read address     (ADDR_WIDTH)
//   apb_write_data      write data       (DATA_WIDTH)
//   apb_read_data_out   last completed read data (registered)
//   PSLVERR             error status of the last completed transfer (registered)
//   xfer_done           one-cycle pulse after a completion or an abort
//   busy                high whenever the FSM is not IDLE
//   PSEL1, PSEL2        slave selects; one-hot or both zero
//   PENABLE, PWRITE     APB enable / direction (1 = write)
//   PADDR, PWDATA       APB address (ADDR_WIDTH-1) / write data
//   PRDATAx, PREADYx,
//   PSLVERRx            slave responses; only the selected slave is used
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
  input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  output logic [DATA_WIDTH-1:0] apb_read_data_out,
  output logic                  PSLVERR,
  output logic                  xfer_done,
  output logic                  busy,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-2:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2,
  input  logic                  PSLVERR1,
  input  logic                  PSLVERR2
);

  // The counter must reach TIMEOUT_CYCLES-1; it keeps at least one bit even
  // when the timeout is disabled.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Captured command
  logic                  r_sel;      // 0 = slave 1, 1 = slave 2
  logic [ADDR_WIDTH-2:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;

  // Command-side results
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_slverr;
  logic                  r_done;

  logic [CNT_W-1:0]      r_cnt;

  // Selected-slave response
  logic                  w_pready;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_pslverr;

  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_capture;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;

  // ---------------------------------------------------------------------------
  // Response mux: the unselected slave is never observed.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pready  = r_sel ? PREADY2  : PREADY1;
    w_prdata  = r_sel ? PRDATA2  : PRDATA1;
    w_pslverr = r_sel ? PSLVERR2 : PSLVERR1;
  end

  always_comb begin
    w_complete = (r_state == ST_ACCESS) && w_pready;
    // Abort on the TIMEOUT_CYCLES-th consecutive stalled ACCESS cycle.
    w_timeout  = TIMEOUT_EN && (r_state == ST_ACCESS) && !w_pready &&
                 (r_cnt == CNT_LAST);
    w_cmd_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (transfer) begin
          w_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_pready) begin
          w_next = transfer ? ST_SETUP : ST_IDLE;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Every entry into SETUP (from IDLE or straight from a completing ACCESS)
  // loads a fresh command.
  assign w_capture = (w_next == ST_SETUP);

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = (r_state != ST_IDLE);
    PSEL1   = busy && !r_sel;
    PSEL2   = busy &&  r_sel;
    PENABLE = (r_state == ST_ACCESS);
  end

  // ---------------------------------------------------------------------------
  // Command capture. The captured values stay stable from SETUP through the
  // final ACCESS cycle because they only load when SETUP is entered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_sel    <= 1'b0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_capture) begin
      r_sel    <= w_cmd_addr[ADDR_WIDTH-1];
      r_paddr  <= w_cmd_addr[ADDR_WIDTH-2:0];
      r_pwrite <= !READ_WRITE;
      r_pwdata <= apb_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion / abort results
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_complete || w_timeout;
      if (w_complete) begin
        if (!r_pwrite) begin
          r_rdata <= w_prdata;
        end
        r_slverr <= w_pslverr;
      end else if (w_timeout) begin
        r_slverr <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter: counts consecutive ACCESS cycles with PREADY low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cnt <= '0;
    end else if (w_capture || w_timeout) begin
      r_cnt <= '0;
    end else if (TIMEOUT_EN && (r_state == ST_ACCESS) && !w_pready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign apb_read_data_out = r_rdata;
  assign PSLVERR           = r_slverr;
  assign xfer_done         = r_done;
  assign PWRITE            = r_pwrite;
  assign PADDR             = r_paddr;
  assign PWDATA            = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned T  = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          transfer;
  logic          READ_WRITE;
  logic [AW-1:0] apb_write_paddr;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out;
  logic          PSLVERR;
  logic          xfer_done;
  logic          busy;
  logic          PSEL1;
  logic          PSEL2;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-2:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA1;
  logic [DW-1:0] PRDATA2;
  logic          PREADY1;
  logic          PREADY2;
  logic          PSLVERR1;
  logic          PSLVERR2;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .PCLK             (PCLK),
    .PRESET           (PRESET),
    .transfer         (transfer),
    .READ_WRITE       (READ_WRITE),
    .apb_write_paddr  (apb_write_paddr),
    .apb_read_paddr   (apb_read_paddr),
    .apb_write_data   (apb_write_data),
    .apb_read_data_out(apb_read_data_out),
    .PSLVERR          (PSLVERR),
    .xfer_done        (xfer_done),
    .busy             (busy),
    .PSEL1            (PSEL1),
    .PSEL2            (PSEL2),
    .PENABLE          (PENABLE),
    .PWRITE           (PWRITE),
    .PADDR            (PADDR),
    .PWDATA           (PWDATA),
    .PRDATA1          (PRDATA1),
    .PRDATA2          (PRDATA2),
    .PREADY1          (PREADY1),
    .PREADY2          (PREADY2),
    .PSLVERR1         (PSLVERR1),
    .PSLVERR2         (PSLVERR2)
  );

  // One command as seen from the command side plus the slave's behaviour.
  typedef struct {
    bit            rw;      // 1 = read
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int unsigned   waits;   // PREADY-low cycles before the slave answers
    logic [DW-1:0] prdata;
    bit            err;
    bit            b2b;     // launched at the completion of the previous one
  } cmd_t;

  cmd_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model of the command-side result registers
  logic [DW-1:0] m_rdata;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input bit rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int unsigned waits,
                              input logic [DW-1:0] prdata, input bit err, input bit b2b);
    cmd_t c;
    c.rw = rw; c.addr = addr; c.wdata = wdata; c.waits = waits;
    c.prdata = prdata; c.err = err; c.b2b = b2b;
    return c;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    transfer   = 1'b1;
    READ_WRITE = c.rw;
    if (c.rw) begin
      apb_read_paddr  = c.addr;
      apb_write_paddr = AW'($urandom);
    end else begin
      apb_write_paddr = c.addr;
      apb_read_paddr  = AW'($urandom);
    end
    apb_write_data = c.wdata;
  endtask

  // Command inputs must be ignored while busy, so scramble them.
  task automatic garbage_cmd();
    transfer        = 1'($urandom);
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = AW'($urandom);
    apb_read_paddr  = AW'($urandom);
    apb_write_data  = DW'($urandom);
  endtask

  // Selected slave gets the given response; the other one answers randomly.
  task automatic drive_slaves(input bit sel, input bit rdy, input logic [DW-1:0] d, input bit e);
    if (!sel) begin
      PREADY1 = rdy; PRDATA1 = d; PSLVERR1 = e;
      PREADY2 = 1'($urandom); PRDATA2 = DW'($urandom); PSLVERR2 = 1'($urandom);
    end else begin
      PREADY2 = rdy; PRDATA2 = d; PSLVERR2 = e;
      PREADY1 = 1'($urandom); PRDATA1 = DW'($urandom); PSLVERR1 = 1'($urandom);
    end
  endtask

  task automatic chk_phase(input string ph, input cmd_t c, input bit en);
    bit sel;
    sel = c.addr[AW-1];
    chk({ph, "_busy"},    32'(busy),    32'(1'b1));
    chk({ph, "_psel1"},   32'(PSEL1),   32'(!sel));
    chk({ph, "_psel2"},   32'(PSEL2),   32'(sel));
    chk({ph, "_penable"}, 32'(PENABLE), 32'(en));
    chk({ph, "_paddr"},   32'(PADDR),   32'(c.addr[AW-2:0]));
    chk({ph, "_pwrite"},  32'(PWRITE),  32'(!c.rw));
    if (!c.rw) chk({ph, "_pwdata"}, 32'(PWDATA), 32'(c.wdata));
  endtask

  // Executes every command in q. Called with the DUT idle, at a negedge.
  task automatic run_queue();
    for (int i = 0; i < q.size(); i++) begin
      cmd_t c;
      bit sel, abort, nb2b;
      int unsigned last;
      c     = q[i];
      sel   = c.addr[AW-1];
      abort = (T != 0) && (c.waits >= T);
      last  = abort ? T - 1 : c.waits;
      nb2b  = (i + 1 < q.size()) && q[i+1].b2b && !abort;

      if (!c.b2b) begin
        drive_cmd(c);
        drive_slaves(sel, 1'b0, DW'($urandom), 1'($urandom));
        @(negedge PCLK);
        chk("setup_done", 32'(xfer_done), 32'(1'b0));
      end
      chk_phase("setup", c, 1'b0);
      garbage_cmd();
      drive_slaves(sel, 1'($urandom), DW'($urandom), 1'($urandom));
      @(negedge PCLK);

      for (int unsigned k = 0; k <= last; k++) begin
        chk_phase("access", c, 1'b1);
        chk("access_done", 32'(xfer_done), 32'(1'b0));
        if (k == last && !abort) begin
          drive_slaves(sel, 1'b1, c.prdata, c.err);
          if (nb2b) drive_cmd(q[i+1]);
          else      transfer = 1'b0;
        end else begin
          drive_slaves(sel, 1'b0, DW'($urandom), 1'($urandom));
          garbage_cmd();
        end
        @(negedge PCLK);
      end

      if (abort) begin
        m_err = 1'b1;
      end else begin
        if (c.rw) m_rdata = c.prdata;
        m_err = c.err;
      end
      chk("end_done",    32'(xfer_done),         32'(1'b1));
      chk("end_pslverr", 32'(PSLVERR),           32'(m_err));
      chk("end_rdata",   32'(apb_read_data_out), 32'(m_rdata));
      chk("end_busy",    32'(busy),              32'(nb2b));
      chk("end_penable", 32'(PENABLE),           32'(1'b0));
      if (!nb2b) begin
        chk("end_psel", 32'({PSEL1, PSEL2}), 32'(2'b00));
        transfer = 1'b0;
        @(negedge PCLK);
        chk("idle_done", 32'(xfer_done), 32'(1'b0));
        chk("idle_busy", 32'(busy),      32'(1'b0));
      end
    end
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_abort;
    PRESET = 1'b1;
    transfer = 1'b0; READ_WRITE = 1'b0;
    apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
    PRDATA1 = '0; PRDATA2 = '0; PREADY1 = 1'b0; PREADY2 = 1'b0;
    PSLVERR1 = 1'b0; PSLVERR2 = 1'b0;
    m_rdata = '0; m_err = 1'b0;

    // Reset state
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_busy",    32'(busy),              32'(1'b0));
    chk("rst_psel",    32'({PSEL1, PSEL2}),    32'(2'b00));
    chk("rst_penable", 32'(PENABLE),           32'(1'b0));
    chk("rst_done",    32'(xfer_done),         32'(1'b0));
    chk("rst_rdata",   32'(apb_read_data_out), 32'(0));
    chk("rst_pslverr", 32'(PSLVERR),           32'(1'b0));
    chk("rst_paddr",   32'(PADDR),             32'(0));
    PRESET = 1'b0;
    @(negedge PCLK);

    // Directed scenarios
    q.push_back(mk(1'b0, 9'h012, 8'hA5, 0, 8'h00, 1'b0, 1'b0)); // zero-wait write
    q.push_back(mk(1'b1, 9'h1F0, 8'h00, 3, 8'h3C, 1'b0, 1'b0)); // read, 3 waits, slave 2
    q.push_back(mk(1'b0, 9'h005, 8'h5A, 0, 8'h00, 1'b0, 1'b0)); // back-to-back pair
    q.push_back(mk(1'b1, 9'h105, 8'h00, 0, 8'hC3, 1'b0, 1'b1));
    q.push_back(mk(1'b1, 9'h0AA, 8'h00, 40, 8'h77, 1'b0, 1'b0)); // timeout
    q.push_back(mk(1'b1, 9'h120, 8'h00, 0, 8'h99, 1'b1, 1'b0)); // slave error
    q.push_back(mk(1'b0, 9'h033, 8'h11, 1, 8'h00, 1'b0, 1'b0)); // clean transfer clears it
    q.push_back(mk(1'b1, 9'h044, 8'h00, T - 1, 8'h6E, 1'b0, 1'b0)); // longest legal stall
    run_queue();

    // Reset during ACCESS
    drive_cmd(mk(1'b1, 9'h0F0, 8'h00, 0, 8'h00, 1'b0, 1'b0));
    drive_slaves(1'b0, 1'b0, 8'hEE, 1'b1);
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_penable", 32'(PENABLE), 32'(1'b1));
    PRESET = 1'b1;
    @(negedge PCLK);
    m_rdata = '0; m_err = 1'b0;
    chk("midrst_busy",    32'(busy),              32'(1'b0));
    chk("midrst_psel",    32'({PSEL1, PSEL2}),    32'(2'b00));
    chk("midrst_penable", 32'(PENABLE),           32'(1'b0));
    chk("midrst_done",    32'(xfer_done),         32'(1'b0));
    chk("midrst_rdata",   32'(apb_read_data_out), 32'(m_rdata));
    chk("midrst_pslverr", 32'(PSLVERR),           32'(m_err));
    chk("midrst_pwrite",  32'(PWRITE),            32'(1'b0));
    chk("midrst_paddr",   32'(PADDR),             32'(0));
    chk("midrst_pwdata",  32'(PWDATA),            32'(0));
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("postrst_done", 32'(xfer_done), 32'(1'b0));
    chk("postrst_busy", 32'(busy),      32'(1'b0));

    // Randomized traffic
    prev_abort = 1'b1;
    for (int n = 0; n < 60; n++) begin
      cmd_t c;
      c.rw     = 1'($urandom);
      c.addr   = AW'($urandom);
      c.wdata  = DW'($urandom);
      c.waits  = ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 4);
      c.prdata = DW'($urandom);
      c.err    = ($urandom_range(0, 3) == 0);
      c.b2b    = !prev_abort && 1'($urandom);
      prev_abort = (c.waits >= T);
      q.push_back(c);
    end
    run_queue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
